// File: rtl/cache_wb_pkg.sv
// Shared types and helpers for the direct-mapped CPU cache.
// Address split, LSB first: word-in-beat, beat, index, tag.
package cache_wb_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StLookup   = 4'd1,
        StWbReq    = 4'd2,
        StWbData   = 4'd3,
        StFillReq  = 4'd4,
        StFillWait = 4'd5,
        StReplay   = 4'd6,
        StWtReq    = 4'd7,
        StWtData   = 4'd8
    } state_t;

    // Smallest n with 2**n >= value; used to size the address fields.
    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned n;
        n = 0;
        while ((64'd1 << n) < 64'(value)) begin
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/cache_wb_array.sv
// Storage for the cache: beat-wide data array and tag array (both synchronous read),
// plus per-line valid/dirty flops cleared by reset.
module cache_wb_array
    import cache_wb_pkg::*;
#(
    parameter int unsigned LINES         = 64,
    parameter int unsigned BEATS         = 4,
    parameter int unsigned MEM_DATA_BITS = 128,
    parameter int unsigned TAG_BITS      = 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ceil_log2(LINES)-1:0]     rd_index,
    input  logic [ceil_log2(BEATS)-1:0]     rd_beat,
    output logic [MEM_DATA_BITS-1:0]        rd_data,
    output logic [TAG_BITS-1:0]             rd_tag,
    input  logic [ceil_log2(LINES)-1:0]     wr_index,
    input  logic                            wr_en,
    input  logic [ceil_log2(BEATS)-1:0]     wr_beat,
    input  logic [MEM_DATA_BITS-1:0]        wr_data,
    input  logic [MEM_DATA_BITS/8-1:0]      wr_mask,
    input  logic                            fill_done,
    input  logic [TAG_BITS-1:0]             fill_tag,
    input  logic                            set_dirty,
    output logic                            line_valid,
    output logic                            line_dirty
);

    localparam int unsigned INDEX_BITS = ceil_log2(LINES);
    localparam int unsigned BEAT_BITS  = ceil_log2(BEATS);
    localparam int unsigned MASK_BITS  = MEM_DATA_BITS / 8;

    logic [MEM_DATA_BITS-1:0] data_mem [LINES*BEATS];
    logic [TAG_BITS-1:0]      tag_mem  [LINES];
    logic [LINES-1:0]         valid_q;
    logic [LINES-1:0]         dirty_q;

    logic [INDEX_BITS+BEAT_BITS-1:0] rd_addr;
    logic [INDEX_BITS+BEAT_BITS-1:0] wr_addr;

    assign rd_addr = {rd_index, rd_beat};
    assign wr_addr = {wr_index, wr_beat};

    always_ff @(posedge clk) begin
        rd_data <= data_mem[rd_addr];
        rd_tag  <= tag_mem[rd_index];
        if (wr_en) begin
            for (int b = 0; b < MASK_BITS; b++) begin
                if (wr_mask[b]) begin
                    data_mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (fill_done) begin
            tag_mem[wr_index] <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[wr_index] <= 1'b1;
            dirty_q[wr_index] <= 1'b0;
        end else if (set_dirty) begin
            dirty_q[wr_index] <= 1'b1;
        end
    end

    // Metadata is looked up for the latched request line, not the read-port address.
    assign line_valid = valid_q[wr_index];
    assign line_dirty = dirty_q[wr_index];

endmodule

// File: rtl/cache_wb.sv
// Direct-mapped cache between the CPU word port and the wide memory port.
// WRITE_BACK=1: write-back/write-allocate; WRITE_BACK=0: write-through/no-allocate.
module cache_wb
    import cache_wb_pkg::*;
#(
    parameter int unsigned LINES          = 64,
    parameter int unsigned BEATS          = 4,
    parameter int unsigned CPU_WIDTH      = 32,
    parameter int unsigned WORD_ADDR_BITS = 30,
    parameter int unsigned MEM_DATA_BITS  = 128,
    parameter int unsigned WRITE_BACK     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req_valid,
    output logic                        cpu_req_ready,
    input  logic [WORD_ADDR_BITS-1:0]   cpu_req_addr,
    input  logic [CPU_WIDTH-1:0]        cpu_req_data,
    input  logic [3:0]                  cpu_req_write,
    output logic                        cpu_resp_valid,
    output logic [CPU_WIDTH-1:0]        cpu_resp_data,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [WORD_ADDR_BITS-ceil_log2(MEM_DATA_BITS/CPU_WIDTH)-1:0] mem_req_addr,
    output logic                        mem_req_rw,
    output logic                        mem_req_data_valid,
    input  logic                        mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]    mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0]  mem_req_data_mask,
    input  logic                        mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]    mem_resp_data
);

    localparam int unsigned RATIO       = MEM_DATA_BITS / CPU_WIDTH;
    localparam int unsigned OFFSET_BITS = ceil_log2(RATIO);
    localparam int unsigned BEAT_BITS   = ceil_log2(BEATS);
    localparam int unsigned INDEX_BITS  = ceil_log2(LINES);
    localparam int unsigned TAG_BITS    = WORD_ADDR_BITS - OFFSET_BITS - BEAT_BITS - INDEX_BITS;
    localparam int unsigned MASK_BITS   = MEM_DATA_BITS / 8;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    state_t state_q, state_d;
    logic [BEAT_BITS-1:0]      cnt_q, cnt_d;
    logic [WORD_ADDR_BITS-1:0] req_addr_q;
    logic [CPU_WIDTH-1:0]      req_data_q;
    logic [3:0]                req_write_q;

    logic [OFFSET_BITS-1:0] req_off;
    logic [BEAT_BITS-1:0]   req_beat;
    logic [INDEX_BITS-1:0]  req_index;
    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  cpu_index;
    logic [BEAT_BITS-1:0]   cpu_beat;

    assign req_off   = req_addr_q[OFFSET_BITS-1:0];
    assign req_beat  = req_addr_q[OFFSET_BITS +: BEAT_BITS];
    assign req_index = req_addr_q[OFFSET_BITS+BEAT_BITS +: INDEX_BITS];
    assign req_tag   = req_addr_q[WORD_ADDR_BITS-1 -: TAG_BITS];
    assign cpu_index = cpu_req_addr[OFFSET_BITS+BEAT_BITS +: INDEX_BITS];
    assign cpu_beat  = cpu_req_addr[OFFSET_BITS +: BEAT_BITS];

    logic [INDEX_BITS-1:0]    rd_index;
    logic [BEAT_BITS-1:0]     rd_beat;
    logic [MEM_DATA_BITS-1:0] rd_data;
    logic [TAG_BITS-1:0]      rd_tag;
    logic                     wr_en;
    logic [BEAT_BITS-1:0]     wr_beat;
    logic [MEM_DATA_BITS-1:0] wr_data;
    logic [MASK_BITS-1:0]     wr_mask;
    logic                     fill_done;
    logic                     set_dirty;
    logic                     line_valid;
    logic                     line_dirty;

    logic                     hit;
    logic                     is_write;
    logic [MASK_BITS-1:0]     word_mask;
    logic [MEM_DATA_BITS-1:0] word_beat;

    assign hit       = line_valid && (rd_tag == req_tag);
    assign is_write  = |req_write_q;
    // Byte enables placed at the word's lane inside the beat.
    assign word_mask = MASK_BITS'(req_write_q) << (req_off * (CPU_WIDTH / 8));
    assign word_beat = {RATIO{req_data_q}};

    cache_wb_array #(
        .LINES        (LINES),
        .BEATS        (BEATS),
        .MEM_DATA_BITS(MEM_DATA_BITS),
        .TAG_BITS     (TAG_BITS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (rd_index),
        .rd_beat   (rd_beat),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .wr_index  (req_index),
        .wr_en     (wr_en),
        .wr_beat   (wr_beat),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .fill_done (fill_done),
        .fill_tag  (req_tag),
        .set_dirty (set_dirty),
        .line_valid(line_valid),
        .line_dirty(line_dirty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_write_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cpu_req_ready && cpu_req_valid) begin
                req_addr_q  <= cpu_req_addr;
                req_data_q  <= cpu_req_data;
                req_write_q <= cpu_req_write;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        rd_index           = req_index;
        rd_beat            = req_beat;
        wr_en              = 1'b0;
        wr_beat            = req_beat;
        wr_data            = word_beat;
        wr_mask            = word_mask;
        fill_done          = 1'b0;
        set_dirty          = 1'b0;
        cpu_req_ready      = 1'b0;
        cpu_resp_valid     = 1'b0;
        cpu_resp_data      = '0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        unique case (state_q)
            StIdle: begin
                cpu_req_ready = 1'b1;
                rd_index      = cpu_index;
                rd_beat       = cpu_beat;
                if (cpu_req_valid) begin
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit && !is_write) begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_data  = rd_data[req_off*CPU_WIDTH +: CPU_WIDTH];
                    state_d        = StIdle;
                end else if (hit) begin
                    wr_en = 1'b1;
                    if (WRITE_BACK != 0) begin
                        set_dirty = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        state_d = StWtReq;
                    end
                end else if (is_write && WRITE_BACK == 0) begin
                    state_d = StWtReq;
                end else if (line_valid && line_dirty) begin
                    state_d = StWbReq;
                end else begin
                    state_d = StFillReq;
                end
            end
            StWbReq: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                // rd_tag keeps re-reading the victim line, so the address stays stable.
                mem_req_addr  = {rd_tag, req_index, {BEAT_BITS{1'b0}}};
                rd_beat       = '0;
                if (mem_req_ready) begin
                    state_d = StWbData;
                end
            end
            StWbData: begin
                mem_req_data_valid = 1'b1;
                mem_req_data_bits  = rd_data;
                mem_req_data_mask  = '1;
                if (mem_req_data_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StFillReq;
                    end
                end
                // Prefetch whichever beat is presented next cycle.
                rd_beat = cnt_d;
            end
            StFillReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, {BEAT_BITS{1'b0}}};
                if (mem_req_ready) begin
                    state_d = StFillWait;
                end
            end
            StFillWait: begin
                if (mem_resp_valid) begin
                    wr_en   = 1'b1;
                    wr_beat = cnt_q;
                    wr_data = mem_resp_data;
                    wr_mask = '1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        fill_done = 1'b1;
                        state_d   = StReplay;
                    end
                end
            end
            StReplay: begin
                state_d = StLookup;
            end
            StWtReq: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = req_addr_q[WORD_ADDR_BITS-1:OFFSET_BITS];
                if (mem_req_ready) begin
                    state_d = StWtData;
                end
            end
            StWtData: begin
                mem_req_data_valid = 1'b1;
                mem_req_data_bits  = word_beat;
                mem_req_data_mask  = word_mask;
                if (mem_req_data_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_wb.sv
// Directed bench for cache_wb: one write-back and one write-through instance share stimulus;
// sel picks which instance's outputs are compared.
module tb_cache_wb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         cpu_req_valid;
    logic [29:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic [3:0]   cpu_req_write;
    logic         mem_req_ready;
    logic         mem_req_data_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    logic         wb_ready, wb_resp_valid, wb_req_valid, wb_rw, wb_data_valid;
    logic [31:0]  wb_resp_data;
    logic [27:0]  wb_addr;
    logic [127:0] wb_bits;
    logic [15:0]  wb_mask;

    logic         wt_ready, wt_resp_valid, wt_req_valid, wt_rw, wt_data_valid;
    logic [31:0]  wt_resp_data;
    logic [27:0]  wt_addr;
    logic [127:0] wt_bits;
    logic [15:0]  wt_mask;

    logic         sel;
    logic         o_ready, o_resp_valid, o_req_valid, o_rw, o_data_valid;
    logic [31:0]  o_resp_data;
    logic [27:0]  o_addr;
    logic [127:0] o_bits;
    logic [15:0]  o_mask;

    assign o_ready      = sel ? wt_ready      : wb_ready;
    assign o_resp_valid = sel ? wt_resp_valid : wb_resp_valid;
    assign o_resp_data  = sel ? wt_resp_data  : wb_resp_data;
    assign o_req_valid  = sel ? wt_req_valid  : wb_req_valid;
    assign o_addr       = sel ? wt_addr       : wb_addr;
    assign o_rw         = sel ? wt_rw         : wb_rw;
    assign o_data_valid = sel ? wt_data_valid : wb_data_valid;
    assign o_bits       = sel ? wt_bits       : wb_bits;
    assign o_mask       = sel ? wt_mask       : wb_mask;

    cache_wb #(.WRITE_BACK(1)) dut_wb (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(wb_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_write(cpu_req_write),
        .cpu_resp_valid(wb_resp_valid), .cpu_resp_data(wb_resp_data),
        .mem_req_valid(wb_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(wb_addr),
        .mem_req_rw(wb_rw), .mem_req_data_valid(wb_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(wb_bits),
        .mem_req_data_mask(wb_mask), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    cache_wb #(.WRITE_BACK(0)) dut_wt (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(wt_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_write(cpu_req_write),
        .cpu_resp_valid(wt_resp_valid), .cpu_resp_data(wt_resp_data),
        .mem_req_valid(wt_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(wt_addr),
        .mem_req_rw(wt_rw), .mem_req_data_valid(wt_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(wt_bits),
        .mem_req_data_mask(wt_mask), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory image: word at word address a holds {2'b01, a}.
    function automatic logic [127:0] beat_data(input logic [27:0] base, input int b);
        logic [127:0] r;
        logic [27:0]  ba;
        ba = base + 28'(b);
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = {2'b01, ba, 2'(k)};
        end
        return r;
    endfunction

    // Presents one request in IDLE; returns in the LOOKUP cycle.
    task automatic cpu_req(input string tag, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] we);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_data  = d;
        cpu_req_write = we;
        #1;
        check({tag, "_ready"}, o_ready, 1);
        tick();
        cpu_req_valid = 1'b0;
        #1;
    endtask

    task automatic wait_mem_req(input string tag);
        for (int i = 0; i < 20 && !o_req_valid; i++) tick();
        check({tag, "_req_valid"}, o_req_valid, 1);
    endtask

    // Serves a fill command and returns four beats; returns in the REPLAY cycle.
    task automatic serve_fill(input string tag, input logic [27:0] base);
        wait_mem_req(tag);
        check({tag, "_rw"}, o_rw, 0);
        check({tag, "_addr"}, o_addr, base);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beat_data(base, b);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp_beat;
        sel                = 1'b0;
        reset              = 1'b1;
        cpu_req_valid      = 1'b0;
        cpu_req_addr       = '0;
        cpu_req_data       = '0;
        cpu_req_write      = '0;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_req_valid", o_req_valid, 0);
        check("rst_resp_valid", o_resp_valid, 0);
        check("rst_data_valid", o_data_valid, 0);

        // 1: cold read miss, fill, then a hit one cycle after acceptance
        cpu_req("t1_miss", 30'h40, 32'h0, 4'b0000);
        check("t1_lookup_resp", o_resp_valid, 0);
        check("t1_lookup_ready", o_ready, 0);
        tick();
        serve_fill("t1_fill", 28'h10);
        tick();
        check("t1_resp_valid", o_resp_valid, 1);
        check("t1_resp_data", o_resp_data, 32'h4000_0040);
        tick();
        cpu_req("t1_hit", 30'h40, 32'h0, 4'b0000);
        check("t1_hit_valid", o_resp_valid, 1);
        check("t1_hit_data", o_resp_data, 32'h4000_0040);
        check("t1_hit_nomem", o_req_valid, 0);
        tick();

        // 2: byte-masked write hits, no memory traffic
        cpu_req("t2_wr_full", 30'h41, 32'h1122_3344, 4'b1111);
        check("t2_wr_noresp", o_resp_valid, 0);
        check("t2_wr_nomem", o_req_valid, 0);
        tick();
        cpu_req("t2_wr_half", 30'h41, 32'hDEAD_BEEF, 4'b0011);
        check("t2_half_nomem", o_req_valid, 0);
        tick();
        check("t2_idle_nomem", o_req_valid, 0);
        cpu_req("t2_rd", 30'h41, 32'h0, 4'b0000);
        check("t2_rd_valid", o_resp_valid, 1);
        check("t2_rd_data", o_resp_data, 32'h1122_BEEF);
        tick();

        // 3: write-allocate into index 5 (tag 1), then evict via read of tag 2
        cpu_req("t3_wr", 30'h450, 32'hCAFE_F00D, 4'b1111);
        tick();
        serve_fill("t3_fill_a", 28'h114);
        tick();
        check("t3_merge_noresp", o_resp_valid, 0);
        tick();
        cpu_req("t3_rd", 30'h850, 32'h0, 4'b0000);
        tick();
        check("t3_wb_valid", o_req_valid, 1);
        check("t3_wb_rw", o_rw, 1);
        check("t3_wb_addr", o_addr, 28'h114);
        check("t3_wb_nodata", o_data_valid, 0);
        tick();
        check("t3_wb_hold_addr", o_addr, 28'h114);
        check("t3_wb_hold_nodata", o_data_valid, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("t3_cmd_dropped", o_req_valid, 0);
        for (int b = 0; b < 4; b++) begin
            exp_beat = beat_data(28'h114, b);
            if (b == 0) exp_beat[31:0] = 32'hCAFE_F00D;
            check("t3_beat_valid", o_data_valid, 1);
            check("t3_beat_mask", o_mask, 16'hFFFF);
            check("t3_beat_bits", o_bits, exp_beat);
            if (b == 1) begin
                tick();
                check("t3_stall_bits", o_bits, exp_beat);
            end
            mem_req_data_ready = 1'b1;
            tick();
            mem_req_data_ready = 1'b0;
            #1;
        end
        check("t3_after_wb_nodata", o_data_valid, 0);
        serve_fill("t3_fill_b", 28'h214);
        tick();
        check("t3_rd_valid", o_resp_valid, 1);
        check("t3_rd_data", o_resp_data, 32'h4000_0850);
        tick();

        // 5: fill command held off for ten cycles
        cpu_req("t5_rd", 30'hC0, 32'h0, 4'b0000);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", o_req_valid, 1);
            check("t5_hold_addr", o_addr, 28'h30);
            check("t5_hold_rw", o_rw, 0);
            check("t5_hold_ready", o_ready, 0);
            tick();
        end
        serve_fill("t5_fill", 28'h30);
        tick();
        check("t5_rd_data", o_resp_data, 32'h4000_00C0);
        tick();

        // 6: reset in the middle of a fill
        cpu_req("t6_rd", 30'h100, 32'h0, 4'b0000);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beat_data(28'h40, b);
            tick();
        end
        mem_resp_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_ready", o_ready, 1);
        check("t6_req_valid", o_req_valid, 0);
        check("t6_addr", o_addr, 0);
        check("t6_rw", o_rw, 0);
        check("t6_data_valid", o_data_valid, 0);
        check("t6_resp_valid", o_resp_valid, 0);
        cpu_req("t6_reread", 30'h40, 32'h0, 4'b0000);
        check("t6_reread_miss", o_resp_valid, 0);
        tick();
        serve_fill("t6_fill", 28'h10);
        tick();
        check("t6_reread_data", o_resp_data, 32'h4000_0040);
        tick();

        // 4: write-through instance, write miss without allocation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel = 1'b1;
        #1;
        cpu_req("t4_wr", 30'h201, 32'h1234_5678, 4'b1111);
        check("t4_wr_noresp", o_resp_valid, 0);
        tick();
        check("t4_cmd_valid", o_req_valid, 1);
        check("t4_cmd_rw", o_rw, 1);
        check("t4_cmd_addr", o_addr, 28'h80);
        check("t4_cmd_nodata", o_data_valid, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("t4_beat_valid", o_data_valid, 1);
        check("t4_beat_mask", o_mask, 16'h00F0);
        check("t4_beat_bits", o_bits, {4{32'h1234_5678}});
        check("t4_beat_nocmd", o_req_valid, 0);
        mem_req_data_ready = 1'b1;
        tick();
        mem_req_data_ready = 1'b0;
        #1;
        check("t4_back_idle", o_ready, 1);
        check("t4_single_beat", o_data_valid, 0);
        cpu_req("t4_rd", 30'h201, 32'h0, 4'b0000);
        check("t4_rd_miss", o_resp_valid, 0);
        tick();
        serve_fill("t4_fill", 28'h80);
        tick();
        check("t4_rd_data", o_resp_data, 32'h4000_0201);
        tick();
        cpu_req("t4_wr_hit", 30'h201, 32'hAAAA_BBBB, 4'b0011);
        tick();
        check("t4_hit_cmd_valid", o_req_valid, 1);
        check("t4_hit_cmd_addr", o_addr, 28'h80);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("t4_hit_mask", o_mask, 16'h0030);
        mem_req_data_ready = 1'b1;
        tick();
        mem_req_data_ready = 1'b0;
        #1;
        cpu_req("t4_rd_hit", 30'h201, 32'h0, 4'b0000);
        check("t4_rd_hit_valid", o_resp_valid, 1);
        check("t4_rd_hit_data", o_resp_data, 32'h4000_BBBB);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_wb.md
Name: cache_wb

Overview:
- Parametrised direct-mapped data/instruction cache between the CPU word port and the 128-bit main-memory port.
- Supports two modes: write-back/write-allocate with per-line dirty bits, or write-through/no-write-allocate.
- Line size (beats), depth and widths are generics.
- Refills and evictions are multi-beat bursts over the memory handshake.

Parameters:
- LINES, 64, number of cache lines (power of 2).
- BEATS, 4, MEM_DATA_BITS beats per line (power of 2).
- CPU_WIDTH, `CPU_INST_BITS (32), CPU word width.
- WORD_ADDR_BITS, `CPU_ADDR_BITS-2 (30), CPU word-address width.
- MEM_DATA_BITS, `MEM_DATA_BITS (128), memory beat width.
- WRITE_BACK, 1, 1 = write-back/allocate, 0 = write-through/no-allocate.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  cache can accept a request.
- cpu_req_addr  in  WORD_ADDR_BITS  word address.
- cpu_req_data  in  CPU_WIDTH  write data.
- cpu_req_write  in  4  byte write enables; 0 = read.
- cpu_resp_valid  out  1  read data valid (reads only).
- cpu_resp_data  out  CPU_WIDTH  read data.
- mem_req_valid  out  1  memory command valid.
- mem_req_ready  in  1  memory accepts command.
- mem_req_addr  out  WORD_ADDR_BITS-log2(MEM_DATA_BITS/CPU_WIDTH)  beat address.
- mem_req_rw  out  1  1 = write, 0 = read.
- mem_req_data_valid  out  1  write beat valid.
- mem_req_data_ready  in  1  memory accepts write beat.
- mem_req_data_bits  out  MEM_DATA_BITS  write beat.
- mem_req_data_mask  out  MEM_DATA_BITS/8  byte mask.
- mem_resp_valid  in  1  read beat valid.
- mem_resp_data  in  MEM_DATA_BITS  read beat.

Behaviour:
- Address split, LSB first: word-in-beat (log2(MEM/CPU)), beat (log2 BEATS), index (log2 LINES), tag (remainder). Defaults: 2, 2, 6, 20.
- Reset:
  - All valid and dirty bits clear.
  - State goes to IDLE.
  - All outputs 0 except cpu_req_ready. cpu_req_ready is 1 from the first cycle after reset deasserts.
- Reset mid-transaction abandons the transaction. Outputs return to reset values on the next cycle.
- IDLE:
  - cpu_req_ready=1.
  - A handshake latches addr/data/write and issues a synchronous array read.
  - Next state: LOOKUP.
- LOOKUP (cpu_req_ready=0):
  - Read hit: cpu_resp_valid=1 and cpu_resp_data valid in this cycle, i.e. one cycle after acceptance. Next state: IDLE.
  - Write hit: byte-masked write of the word. If WRITE_BACK, set dirty and go to IDLE; otherwise go to WT_REQ.
  - Read miss, or write miss with WRITE_BACK: go to WB_REQ if victim is valid and dirty, else FILL_REQ.
  - Write miss with WRITE_BACK=0: go to WT_REQ; no allocate.
- WB_REQ:
  - Drive mem_req_valid, rw=1, addr={victim_tag,index,0s}; hold all of these stable until mem_req_ready.
  - Next state: WB_DATA.
- WB_DATA:
  - Send BEATS beats in ascending order, mask all ones; a beat advances on mem_req_data_ready.
  - Beat counter wraps to 0 after the last beat. Next state: FILL_REQ.
  - Data beats are never presented before the command handshake completes.
- FILL_REQ:
  - mem_req_valid, rw=1'b0, addr={req_tag,index,0s}; hold until ready.
  - Next state: FILL_WAIT.
- FILL_WAIT:
  - Each mem_resp_valid writes beat[counter].
  - On the last beat: set valid, clear dirty, write tag. Next state: REPLAY.
  - mem_resp_valid outside FILL_WAIT is ignored.
- REPLAY:
  - Re-read arrays with the latched address; next state LOOKUP, which now hits.
  - A write miss in write-back mode merges the write there and sets dirty.
- WT_REQ then WT_DATA:
  - One write command: addr = beat address of the request.
  - One data beat: cpu word replicated across the beat; mask = cpu_req_write shifted to the word-in-beat position.
  - Next state: IDLE.
- cpu_req_ready=1 only in IDLE; one request per ≥2 cycles. No cpu_resp_valid for writes.
- A dirty bit is never set when WRITE_BACK=0.

Decomposition:
- Shared package / const.vh additions:
  - field widths derived with `ceilLog2: OFFSET_BITS, BEAT_BITS, INDEX_BITS, TAG_BITS;
  - state encodings IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_WAIT, REPLAY, WT_REQ, WT_DATA (4-bit).
- Sub-module cache_array:
  - data array of LINES*BEATS beats, synchronous read, byte-mask write;
  - tag array;
  - flop-based valid/dirty vectors cleared by reset.

Test Plan:
1. Reset, read 0x0000040 → FILL_REQ addr 0x0000010 with rw=0. Return 4 beats; cpu_resp_data = word 0 of beat 0. Repeat the read → cpu_resp_valid one cycle after acceptance, no mem_req_valid.
2. WRITE_BACK=1, write hit 0xDEADBEEF with write=4'b0011 over 0x11223344 → next read returns 0x1122BEEF, no memory traffic.
3. Write tag A at index 5, then read tag B at index 5 → WB_REQ addr={A,5,00}, rw=1. 4 beats, mask 16'hFFFF, first beat carries the written word. Then FILL_REQ addr={B,5,00}.
4. WRITE_BACK=0, write miss word-in-beat 1, write=4'b1111 → one command plus one beat, mask 16'h00F0. A following read of the same address misses.
5. Hold mem_req_ready=0 for 10 cycles during FILL_REQ → mem_req_valid/addr/rw stable throughout, cpu_req_ready=0.
6. Assert reset for one cycle mid-FILL_WAIT (after beat 1) → outputs return to reset values. A previously cached address then misses.
